// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and width helper for the round-robin register arbiter.
package rr_arb_pkg;
  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_e;
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin picker, first request at or after ptr wins.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_onehot_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);
  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    // Walk offsets from farthest to nearest so the nearest request overwrites.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr_i) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[j]) begin
        gnt_onehot_o    = '0;
        gnt_onehot_o[j] = 1'b1;
        gnt_idx_o       = IDX_W'(j);
        any_o           = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter feeding one registered valid/ready stage.
// Optional per-requester saturating grant counters under RR_ARB_GRANT_CNT_EN.
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16,
  localparam int IDX_W    = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [IDX_W-1:0]       src_o
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [N_REQ*CNT_WIDTH-1:0] grant_cnt_o
`endif
);
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d, sel_data;
  logic [IDX_W-1:0]  src_q, src_d, ptr_q, ptr_d, gnt_idx;
  logic [N_REQ-1:0]  gnt_onehot;
  logic              any, load, xfer;
  rr_arb_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i        (req_valid_i),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_o        (any)
  );
  assign load        = (state_q == EMPTY) | ready_i;
  assign xfer        = load & any;
  assign req_ready_o = (load & ~rst) ? gnt_onehot : '0;
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_REQ; k++)
      sel_data = sel_data | (gnt_onehot[k] ? req_data_i[k*WIDTH +: WIDTH] : '0);
  end
  always_comb begin
    state_d = load ? (any ? FULL : EMPTY) : state_q;
    data_d  = xfer ? sel_data : data_q;
    src_d   = xfer ? gnt_idx : src_q;
    ptr_d   = xfer ? ((gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end
  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);
  assign src_o   = src_q;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (rst) cnt_q[g] <= '0;
      else if (xfer && gnt_onehot[g] && cnt_q[g] != '1) cnt_q[g] <= cnt_q[g] + 1'b1;
    end
    assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end
`endif
endmodule

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: directed checks of the round-robin register arbiter.
module tb_rr_reg_arbiter;
  import rr_arb_pkg::*;
  localparam int N = 4, W = 8, CW = 2;
  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid, req_ready;
  logic [W-1:0]   data;
  logic           valid, ready;
  logic [1:0]     src;
  int             n_chk = 0, n_pass = 0;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [N*CW-1:0] gcnt;
`endif
  rr_reg_arbiter #(.N_REQ(N), .WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .src_o       (src)
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    .grant_cnt_o (gcnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".data"}, 32'(data), 32'(d));
    chk({tag, ".src"}, 32'(src), 32'(s));
  endtask
  initial begin
    rst       = 1'b1;
    req_valid = 4'hF;
    ready     = 1'b1;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.ready", 32'(req_ready), 32'h0);
      chk_out("rst", 1'b0, 8'h00, 2'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("rr.ready", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      chk_out("rr", 1'b1, 8'(8'h10 + i % 4), 2'(i % 4));
    end
    req_valid = 4'b0010;
    tick();
    chk_out("ptr2", 1'b1, 8'h11, 2'd1);
    req_valid = 4'b1010;
    #1 chk("sparse0.ready", 32'(req_ready), 32'b1000);
    tick();
    chk_out("sparse0", 1'b1, 8'h13, 2'd3);
    chk("sparse1.ready", 32'(req_ready), 32'b0010);
    tick();
    chk_out("sparse1", 1'b1, 8'h11, 2'd1);
    chk("sparse2.ready", 32'(req_ready), 32'b1000);
    tick();
    chk_out("sparse2", 1'b1, 8'h13, 2'd3);
    chk("bp_load.ready", 32'(req_ready), 32'b0010);
    tick();
    chk_out("bp_load", 1'b1, 8'h11, 2'd1);
    ready     = 1'b0;
    req_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.ready", 32'(req_ready), 32'h0);
      tick();
      chk_out("bp", 1'b1, 8'h11, 2'd1);
    end
    ready = 1'b1;
    #1 chk("bp_rel.ready", 32'(req_ready), 32'b0100);
    tick();
    chk_out("bp_rel", 1'b1, 8'h12, 2'd2);
    req_valid = 4'h0;
    #1 chk("drain.ready", 32'(req_ready), 32'h0);
    tick();
    chk_out("drain", 1'b0, 8'h12, 2'd2);
    req_valid = 4'b0001;
    #1 chk("wrap.ready", 32'(req_ready), 32'b0001);
    tick();
    chk_out("wrap", 1'b1, 8'h10, 2'd0);
    rst = 1'b1;
    #1 chk("midrst.ready", 32'(req_ready), 32'h0);
    tick();
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
`ifdef RR_ARB_GRANT_CNT_EN
    chk("cnt.rst", 32'(gcnt), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("cnt0", 32'(gcnt[1:0]), 32'((i < 3) ? i + 1 : 3));
      chk("cnt_other", 32'(gcnt[7:2]), 32'h0);
    end
`endif
    rst = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
